// File: rtl/tt_um_spike_rate_decoder.sv
// Spike train receiver: decodes a 1-bit spike stream into a spike count
// per fixed window (rate code) and an inter-spike interval (temporal code).
// Arms on the first spike after IDLE; window boundaries are phase-locked to it.
//
// state | meaning
// IDLE  | waiting for the first spike; no window or interval is being timed
// RUN   | windows and intervals running; left only via clear or reset
`timescale 1ns/1ps
module tt_um_spike_rate_decoder #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Window counter value on the closing cycle of each window.
  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

  logic spike_in, clear, sel;
  assign spike_in = ui_in[0];
  assign clear    = ui_in[1];
  assign sel      = ui_in[2];

  state_t     state_q, state_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] spk_cnt_q, spk_cnt_d;
  logic [7:0] isi_cnt_q, isi_cnt_d;
  logic [7:0] rate_q, rate_d;
  logic [7:0] isi_q, isi_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  // One extra bit on each sum exposes the carry used for saturation and overflow.
  logic [8:0] spk_sum, isi_sum;
  assign spk_sum = {1'b0, spk_cnt_q} + {8'b0, spike_in};
  assign isi_sum = {1'b0, isi_cnt_q} + 9'd1;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Next-state: FSM transitions plus the parallel window and interval decodes.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    spk_cnt_d = spk_cnt_q;
    isi_cnt_d = isi_cnt_q;
    rate_d    = rate_q;
    isi_d     = isi_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    if (clear) begin
      state_d   = IDLE;
      win_cnt_d = 8'd0;
      spk_cnt_d = 8'd0;
      isi_cnt_d = 8'd0;
      rate_d    = 8'd0;
      isi_d     = 8'd0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (spike_in) begin
            // The arming spike occupies cycle 0 of the first window.
            state_d   = RUN;
            win_cnt_d = 8'd1;
            spk_cnt_d = 8'd1;
            isi_cnt_d = 8'd1;
          end
        end
        RUN: begin
          if (win_cnt_q == WIN_LAST) begin
            rate_d    = sat8(spk_sum);
            valid_d   = 1'b1;
            win_cnt_d = 8'd0;
            spk_cnt_d = 8'd0;
          end else begin
            win_cnt_d = win_cnt_q + 8'd1;
            spk_cnt_d = sat8(spk_sum);
          end
          if (spk_sum[8]) ovf_d = 1'b1;
          if (spike_in) begin
            isi_d     = isi_cnt_q;
            isi_cnt_d = 8'd1;
          end else begin
            isi_cnt_d = sat8(isi_sum);
            if (isi_sum[8]) ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; ena low freezes everything except the valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_cnt_q <= 8'd0;
      spk_cnt_q <= 8'd0;
      isi_cnt_q <= 8'd0;
      rate_q    <= 8'd0;
      isi_q     <= 8'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      isi_cnt_q <= isi_cnt_d;
      rate_q    <= rate_d;
      isi_q     <= isi_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign uo_out  = sel ? isi_q : rate_q;
  assign uio_out = {5'b0, ovf_q, (state_q == RUN), valid_q};
  assign uio_oe  = 8'h07;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: doc/tt_um_spike_rate_decoder.md
Name: tt_um_spike_rate_decoder

Overview:
Receiver end of the neuron spike interface: consumes a 1-bit spike train (as emitted by the LSNN neuron tile) and decodes it back into numeric form. Two decodes run in parallel: spike count per fixed window (rate code) and inter-spike interval in cycles (temporal code). A small FSM arms on the first spike, and results are latched with a one-cycle valid strobe. Uses the standard Tiny Tapeout tile pinout.

Parameters:
WINDOW, 16, rate window length in clock cycles; legal range 2..256; window counter is 8 bits.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset; all state cleared while low
ena  input  1  tile enable; low = freeze all state
ui_in  input  8  [0] spike_in (1 spike per cycle sampled high), [1] clear (sync, active-high), [2] sel (0 = rate, 1 = ISI), [7:3] ignored
uo_out  output  8  sel ? isi_reg : rate_reg (combinational mux of registers)
uio_in  input  8  unused
uio_out  output  8  [0] valid, [1] running, [2] overflow, [7:3] = 0
uio_oe  output  8  constant 8'h07

Behaviour:
- Reset (rst_n low, async): state=IDLE; win_cnt, spk_cnt, isi_cnt, rate_reg, isi_reg = 0; valid=0, overflow=0. Hence uo_out=0 and uio_out=0.
- Priority on each posedge: rst_n > ena low (hold all regs; valid forced 0) > clear > normal operation.
- clear=1: same effect as reset, synchronous; a spike in the same cycle is discarded.
- FSM has two states: IDLE and RUN. running = (state==RUN).
- IDLE, spike_in=1:
  - go to RUN; win_cnt<=1, spk_cnt<=1, isi_cnt<=1.
  - isi_reg and rate_reg are unchanged; the first spike has no predecessor.
- IDLE, no spike: hold.
- RUN, window logic each cycle:
  - If win_cnt==WINDOW-1, this is the last cycle of the window:
    - rate_reg <= sat255(spk_cnt + spike_in).
    - valid <= 1 (high for exactly the next cycle).
    - win_cnt<=0, spk_cnt<=0.
  - Otherwise: win_cnt<=win_cnt+1; spk_cnt<=sat255(spk_cnt+spike_in); valid<=0.
  - Back-to-back windows run with no gap cycle. Window boundaries are phase-locked to the first spike after IDLE.
- RUN, ISI logic each cycle:
  - spike_in=1: isi_reg<=isi_cnt, isi_cnt<=1.
  - Otherwise: isi_cnt<=sat255(isi_cnt+1).
  - ISI value = cycle distance between consecutive spikes (consecutive-cycle spikes give 1).
- overflow (sticky): set when spk_cnt would exceed 255 or isi_cnt would exceed 255. Cleared only by reset or clear.
- RUN never returns to IDLE except via clear or reset.
- Arithmetic: all counters are unsigned 8-bit and saturate at 255; none wrap.
- Output latency: a new rate_reg/isi_reg appears on uo_out in the cycle after the closing edge, coincident with valid for rate.
- Reset asserted mid-window: partial counts are discarded and no valid pulse is produced.

Test Plan:
1. Reset then idle 50 cycles, no spikes -> uo_out=0, uio_out=0, running=0, no valid.
2. WINDOW=16, spike every 4th cycle starting cycle 0 -> running=1 after first edge; valid pulses every 16 cycles; rate_reg=4; sel=1 gives isi_reg=4 after 2nd spike; overflow=0.
3. WINDOW=16, spike_in held high 100 cycles -> each window rate_reg=16, isi_reg=1, overflow=0. Same stimulus with WINDOW=256 -> rate_reg=255, overflow=1.
4. One spike, 300 idle cycles, second spike -> isi_reg=255, overflow=1. After clear -> overflow=0, uo_out=0, running=0.
5. In RUN, assert clear together with spike_in -> state IDLE, no count recorded. Next lone spike re-arms with win_cnt phase restarted (valid exactly WINDOW cycles later).
6. ena low for 10 cycles mid-window with spikes present -> counters frozen, valid never asserts. After ena high, valid arrives 10 cycles later than without the pause, and spikes during the freeze are not counted.
7. Async rst_n pulse between clock edges mid-window -> outputs 0 immediately and no valid pulse follows.
